// File: rtl/null_source_mc.sv
// rtl/null_source_mc.sv - multi-channel round-robin CHDR null-source traffic generator
// Optional build macro NULL_SRC_TIMESTAMP_EN adds a cycle-count timestamp line after each header.
module null_source_mc #(
    parameter logic [7:0] BASE     = 8'd0,
    parameter int         WIDTH    = 64,
    parameter int         NUM_CHAN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [3:0]       o_chan,
    output logic             o_done
);

`ifdef NULL_SRC_TIMESTAMP_EN
    localparam int         TS_LINES = 1;
    localparam logic [3:0] FLAGS    = 4'b0010;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_TS, S_PAY, S_GAP} state_t;
`else
    localparam int         TS_LINES = 0;
    localparam logic [3:0] FLAGS    = 4'b0000;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_GAP} state_t;
`endif

    localparam int          LANES    = WIDTH / 32;
    localparam logic [15:0] MASK_ALL = 16'((17'd1 << NUM_CHAN) - 17'd1);

    state_t      state;
    logic [31:0] sid;
    logic [15:0] len;
    logic [15:0] rate;
    logic        enable;
    logic [15:0] mask;
    logic [31:0] limit;

    logic [31:0] sid_s;
    logic [15:0] len_s;
    logic [15:0] rate_s;
    logic [11:0] seq_s;
    logic [15:0] k;
    logic [15:0] gap_cnt;
    logic [31:0] sent;
    logic [3:0]  ptr;
    logic [11:0] seq [16];

    logic        xfer;
    logic        go;
    logic        clr;
    logic [15:0] len_eff;
    logic [3:0]  pick;
    logic        found;
    logic [4:0]  idx;

`ifdef NULL_SRC_TIMESTAMP_EN
    logic [63:0] ts_cnt;
    logic [63:0] ts_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 64'd1;
    end

    function automatic logic [WIDTH-1:0] ts_line(input logic [63:0] t);
        logic [WIDTH-1:0] r;
        r = '0;
        r[63:0] = t;
        return r;
    endfunction
`endif

    function automatic logic [WIDTH-1:0] hdr_line(input logic [3:0] c, input logic [11:0] s,
                                                  input logic [31:0] id, input logic [15:0] n);
        logic [WIDTH-1:0] r;
        logic [31:0]      bytes;
        bytes = 32'(WIDTH / 8) * (32'(1 + TS_LINES) + {16'd0, n});
        r = '0;
        r[63:60] = FLAGS;
        r[59:48] = s;
        r[47:32] = bytes[15:0];
        r[31:0]  = id + {28'd0, c};
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] pay_line(input logic [3:0] c, input logic [11:0] s,
                                                  input logic [15:0] kk);
        logic [31:0] lane;
        lane = {4'd0, c, s[7:0], kk};
        return {LANES{lane}};
    endfunction

    assign xfer    = o_tvalid & o_tready;
    assign len_eff = (len == 16'd0) ? 16'd1 : len;
    assign go      = enable && (mask != 16'd0) && ((limit == 32'd0) || (sent < limit));
    assign clr     = set_stb && (set_addr == BASE + 8'd3) && set_data[0] && !enable;

    // First enabled channel strictly after the last one served, wrapping at NUM_CHAN.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(NUM_CHAN)) idx = idx - 5'(NUM_CHAN);
            if (!found && mask[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sid      <= '0;
            len      <= '0;
            rate     <= '0;
            enable   <= 1'b0;
            mask     <= MASK_ALL;
            limit    <= '0;
            sid_s    <= '0;
            len_s    <= 16'd1;
            rate_s   <= '0;
            seq_s    <= '0;
            k        <= '0;
            gap_cnt  <= '0;
            sent     <= '0;
            ptr      <= '0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
            o_chan   <= '0;
            o_done   <= 1'b0;
            for (int i = 0; i < 16; i++) seq[i] <= '0;
`ifdef NULL_SRC_TIMESTAMP_EN
            ts_s     <= '0;
`endif
        end else begin
            o_done <= (limit != 32'd0) && (sent >= limit);

            if (set_stb) begin
                if (set_addr == BASE)         sid    <= set_data;
                if (set_addr == BASE + 8'd1)  len    <= set_data[15:0];
                if (set_addr == BASE + 8'd2)  rate   <= set_data[15:0];
                if (set_addr == BASE + 8'd3)  enable <= set_data[0];
                if (set_addr == BASE + 8'd4)  mask   <= MASK_ALL & set_data[15:0];
                if (set_addr == BASE + 8'd5)  limit  <= set_data;
            end

            case (state)
                S_IDLE: begin
                    if (go) begin
                        ptr      <= pick;
                        o_chan   <= pick;
                        sid_s    <= sid;
                        len_s    <= len_eff;
                        rate_s   <= rate;
                        seq_s    <= seq[pick];
                        k        <= '0;
                        o_tvalid <= 1'b1;
                        o_tlast  <= 1'b0;
                        o_tdata  <= hdr_line(pick, seq[pick], sid, len_eff);
`ifdef NULL_SRC_TIMESTAMP_EN
                        ts_s     <= ts_cnt;
`endif
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
`ifdef NULL_SRC_TIMESTAMP_EN
                        o_tdata <= ts_line(ts_s);
                        state   <= S_TS;
`else
                        o_tdata <= pay_line(o_chan, seq_s, 16'd0);
                        o_tlast <= (len_s == 16'd1);
                        state   <= S_PAY;
`endif
                    end
                end
`ifdef NULL_SRC_TIMESTAMP_EN
                S_TS: begin
                    if (xfer) begin
                        o_tdata <= pay_line(o_chan, seq_s, 16'd0);
                        o_tlast <= (len_s == 16'd1);
                        state   <= S_PAY;
                    end
                end
`endif
                S_PAY: begin
                    if (xfer) begin
                        if (o_tlast) begin
                            seq[o_chan] <= seq_s + 12'd1;
                            if (sent != 32'hFFFF_FFFF) sent <= sent + 32'd1;
                            o_tvalid <= 1'b0;
                            o_tlast  <= 1'b0;
                            o_tdata  <= '0;
                            if (rate_s == 16'd0) begin
                                state <= S_IDLE;
                            end else begin
                                gap_cnt <= rate_s - 16'd1;
                                state   <= S_GAP;
                            end
                        end else begin
                            k       <= k + 16'd1;
                            o_tdata <= pay_line(o_chan, seq_s, k + 16'd1);
                            o_tlast <= (({1'b0, k} + 17'd2) == {1'b0, len_s});
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'd0) state <= S_IDLE;
                    else                  gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase

            // Re-enabling restarts the run: counters cleared, overriding any same-cycle update.
            if (clr) begin
                sent <= '0;
                for (int i = 0; i < 16; i++) seq[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_null_source_mc.sv
// tb/tb_null_source_mc.sv - scoreboard bench for null_source_mc
`timescale 1ns/1ps
module tb_null_source_mc;

    localparam int WIDTH    = 64;
    localparam int NUM_CHAN = 4;
`ifdef NULL_SRC_TIMESTAMP_EN
    localparam int         TS_LINES = 1;
    localparam logic [3:0] FLAGS    = 4'b0010;
`else
    localparam int         TS_LINES = 0;
    localparam logic [3:0] FLAGS    = 4'b0000;
`endif

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             set_stb  = 1'b0;
    logic [7:0]       set_addr = '0;
    logic [31:0]      set_data = '0;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready = 1'b1;
    logic [3:0]       o_chan;
    logic             o_done;

    null_source_mc #(.BASE(8'd0), .WIDTH(WIDTH), .NUM_CHAN(NUM_CHAN)) dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_chan(o_chan), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [3:0]       chan;
        logic             is_ts;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the configuration and per-channel state
    logic [31:0] m_sid  = '0;
    logic [15:0] m_len  = '0;
    logic [15:0] m_mask = 16'h000F;
    logic        m_en   = 1'b0;
    logic [3:0]  m_ptr  = '0;
    logic [11:0] m_seq [16] = '{default: 12'd0};

    function automatic logic [3:0] next_chan();
        for (int i = 1; i <= NUM_CHAN; i++) begin
            int j;
            j = (int'(m_ptr) + i) % NUM_CHAN;
            if (m_mask[j]) return 4'(j);
        end
        return m_ptr;
    endfunction

    task automatic push_packets(input int n);
        for (int p = 0; p < n; p++) begin
            logic [3:0]  c;
            logic [15:0] ln;
            logic [31:0] lane;
            int          bytes;
            beat_t       b;
            c     = next_chan();
            ln    = (m_len == 16'd0) ? 16'd1 : m_len;
            bytes = 8 * (1 + TS_LINES + int'(ln));
            b.data  = {FLAGS, m_seq[c], 16'(bytes), m_sid + 32'(c)};
            b.last  = 1'b0;
            b.chan  = c;
            b.is_ts = 1'b0;
            exp_q.push_back(b);
            if (TS_LINES != 0) begin
                b.data  = '0;
                b.is_ts = 1'b1;
                exp_q.push_back(b);
                b.is_ts = 1'b0;
            end
            for (int kk = 0; kk < int'(ln); kk++) begin
                lane   = {4'd0, c, m_seq[c][7:0], 16'(kk)};
                b.data = {lane, lane};
                b.last = (kk == int'(ln) - 1);
                exp_q.push_back(b);
            end
            m_seq[c] = m_seq[c] + 12'd1;
            m_ptr    = c;
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'd0) m_sid = d;
        if (a == 8'd1) m_len = d[15:0];
        if (a == 8'd4) m_mask = d[15:0] & 16'((1 << NUM_CHAN) - 1);
        if (a == 8'd3) begin
            if (d[0] && !m_en) for (int i = 0; i < 16; i++) m_seq[i] = '0;
            m_en = d[0];
        end
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks holds and inter-packet gaps
    int               beats    = 0;
    int               low_cnt  = 0;
    int               gap_exp  = -1;
    bit               after_last = 0;
    bit               stalled  = 0;
    bit               rand_ready = 0;
    logic [WIDTH-1:0] held_d;
    logic             held_l;
    logic [3:0]       held_c;
    logic [63:0]      last_ts  = '0;

    always @(posedge clk) begin
        #1;
        o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin : mon
        beat_t e;
        if (!reset) begin
            if (stalled) begin
                check("stall_data", o_tdata, held_d);
                check("stall_ctl", 64'({o_tvalid, o_tlast, o_chan}), 64'({1'b1, held_l, held_c}));
            end
            stalled = o_tvalid && !o_tready;
            held_d  = o_tdata;
            held_l  = o_tlast;
            held_c  = o_chan;
            if (o_tvalid) begin
                if (after_last && gap_exp >= 0) check("gap", 64'(low_cnt), 64'(gap_exp));
                after_last = 0;
                low_cnt    = 0;
                if (o_tready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_ts) begin
                            check("ts_incr", 64'(o_tdata > last_ts), 64'(1));
                            last_ts = o_tdata[63:0];
                        end else begin
                            check("tdata", o_tdata, e.data);
                        end
                        check("tlast", 64'(o_tlast), 64'(e.last));
                        check("chan", 64'(o_chan), 64'(e.chan));
                    end
                    if (o_tlast) after_last = 1;
                end
            end else begin
                low_cnt++;
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
        repeat (5) @(negedge clk);
    endtask

    task automatic run_test(input int n, input int gap, input int budget);
        int b0;
        int t;
        gap_exp = -1;
        b0 = beats;
        push_packets(n);
        cfg(8'd3, 32'd1);
        @(negedge clk);
        check("done_clear", 64'(o_done), 64'(0));
        t = 0;
        while (beats == b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("first_beat", 64'(beats > b0), 64'(1));
        gap_exp = gap;
        wait_drain(budget);
        gap_exp = -1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(o_tvalid), 64'(0));
        check("rst_tlast", 64'(o_tlast), 64'(0));
        check("rst_tdata", o_tdata, 64'(0));
        check("rst_chan", 64'(o_chan), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_after_rst", 64'(o_tvalid), 64'(0));

        // Single channel, long gap
        cfg(8'd0, 32'hDEADBEEF);
        cfg(8'd1, 32'd8);
        cfg(8'd2, 32'h20);
        cfg(8'd4, 32'h1);
        cfg(8'd5, 32'd3);
        run_test(3, 33, 500);
        cfg(8'd3, 32'd0);

        // Two interleaved channels, no gap
        cfg(8'd1, 32'd2);
        cfg(8'd2, 32'd0);
        cfg(8'd4, 32'hA);
        cfg(8'd5, 32'd4);
        run_test(4, 1, 200);
        cfg(8'd3, 32'd0);

        // Random backpressure
        rand_ready = 1;
        cfg(8'd1, 32'd5);
        cfg(8'd2, 32'd3);
        cfg(8'd4, 32'h7);
        cfg(8'd5, 32'd6);
        run_test(6, -1, 1000);
        rand_ready = 0;
        cfg(8'd3, 32'd0);

        // Packet limit, then restart
        cfg(8'd1, 32'd3);
        cfg(8'd2, 32'd1);
        cfg(8'd4, 32'h1);
        cfg(8'd5, 32'd3);
        run_test(3, 2, 300);
        repeat (40) @(negedge clk);
        check("done_set", 64'(o_done), 64'(1));
        check("idle_at_limit", 64'(o_tvalid), 64'(0));
        cfg(8'd3, 32'd0);
        run_test(3, 2, 300);
        cfg(8'd3, 32'd0);

        // Disable mid-packet: current packet completes, nothing follows
        begin
            int b0;
            int t;
            cfg(8'd1, 32'd8);
            cfg(8'd2, 32'd2);
            cfg(8'd5, 32'd0);
            b0 = beats;
            push_packets(1);
            cfg(8'd3, 32'd1);
            t = 0;
            while (beats < b0 + 3 + TS_LINES && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("mid_pkt_reached", 64'(beats >= b0 + 3 + TS_LINES), 64'(1));
            cfg(8'd3, 32'd0);
            wait_drain(200);
            repeat (40) @(negedge clk);
            check("idle_after_disable", 64'(o_tvalid), 64'(0));
        end

        // Sequence wrap on one channel, LEN=0 treated as one line
        cfg(8'd1, 32'd0);
        cfg(8'd2, 32'd0);
        cfg(8'd4, 32'h1);
        cfg(8'd5, 32'd4100);
        run_test(4100, 1, 30000);
        repeat (10) @(negedge clk);
        check("done_wrap", 64'(o_done), 64'(1));
        cfg(8'd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
